// File: rtl/sbox_table_loader_pkg.sv
// Shared definitions for the masked S-box table loader: FSM encoding, checksum
// width, default geometry and the checksum accumulate helper.
package sbox_table_loader_pkg;

  localparam int CSUM_W      = 16;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_RD_LAT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // Modular 16-bit additive checksum; callers zero-extend the table word.
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [CSUM_W-1:0] val);
    return acc + val;
  endfunction

endpackage

// File: rtl/sbox_table_loader_if.sv
// Byte-stream handshake plus BRAM write/read port bundle between the loader
// (master) and the host stream / table memory (slave).
interface sbox_table_loader_if
  import sbox_table_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  modport master (
    input  in_data, in_valid, rd_data,
    output in_ready, wr_addr, wr_data, wr_en, rd_addr, rd_en
  );

  modport slave (
    output in_data, in_valid, rd_data,
    input  in_ready, wr_addr, wr_data, wr_en, rd_addr, rd_en
  );
endinterface

// File: rtl/sbox_rd_valid_pipe.sv
// RD_LAT-deep valid shift register that tracks outstanding BRAM reads; valid_out
// lines up with returning read data, empty_next predicts an idle pipe.
module sbox_rd_valid_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic valid_out,
  output logic empty,
  output logic empty_next
);
  logic [RD_LAT-1:0] vld_r;
  logic [RD_LAT-1:0] shifted_s;

  assign shifted_s  = vld_r << 1;
  assign valid_out  = vld_r[RD_LAT-1];
  assign empty      = ~|vld_r;
  assign empty_next = ~issue & ~|shifted_s;

  // Shift in one bit per issued read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= {RD_LAT{1'b0}};
    end else begin
      vld_r <= shifted_s | RD_LAT'(issue);
    end
  end
endmodule

// File: rtl/sbox_table_loader.sv
// Loads the masked S-box table from a byte stream, reads it back to verify a
// checksum, and holds S-box users off the table (busy) while doing so.
module sbox_table_loader
  import sbox_table_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  sbox_table_loader_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CSUM_W-1:0]   sum
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_r, state_next_s;
  logic [ADDR_W-1:0]   cnt_r, cnt_next_s;
  logic [CSUM_W-1:0]   wsum_r, wsum_next_s;
  logic [CSUM_W-1:0]   rsum_r, rsum_next_s;
  logic [CSUM_W-1:0]   sum_r, sum_next_s;
  logic                busy_r, busy_next_s;
  logic                done_r, done_next_s;
  logic                err_r, err_next_s;
  logic                in_ready_s, wr_en_s, rd_en_s;
  logic                rd_valid_s, pipe_empty_s, pipe_empty_next_s;

  sbox_rd_valid_pipe #(.RD_LAT(RD_LAT)) u_rd_valid_pipe (
    .clk        (clk),
    .rst        (rst),
    .issue      (rd_en_s),
    .valid_out  (rd_valid_s),
    .empty      (pipe_empty_s),
    .empty_next (pipe_empty_next_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {ADDR_W{1'b0}};
      wsum_r  <= {CSUM_W{1'b0}};
      rsum_r  <= {CSUM_W{1'b0}};
      sum_r   <= {CSUM_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      wsum_r  <= wsum_next_s;
      rsum_r  <= rsum_next_s;
      sum_r   <= sum_next_s;
      busy_r  <= busy_next_s;
      done_r  <= done_next_s;
      err_r   <= err_next_s;
    end
  end

  // Next-state, counter/checksum updates and port strobes.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    wsum_next_s  = wsum_r;
    sum_next_s   = sum_r;
    busy_next_s  = busy_r;
    done_next_s  = done_r;
    err_next_s   = err_r;
    in_ready_s   = 1'b0;
    wr_en_s      = 1'b0;
    rd_en_s      = 1'b0;
    if (rd_valid_s) begin
      rsum_next_s = csum_add(rsum_r, CSUM_W'(bus.rd_data));
    end else begin
      rsum_next_s = rsum_r;
    end

    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_next_s = ST_LOAD;
          cnt_next_s   = {ADDR_W{1'b0}};
          wsum_next_s  = {CSUM_W{1'b0}};
          rsum_next_s  = {CSUM_W{1'b0}};
          busy_next_s  = 1'b1;
          done_next_s  = 1'b0;
          err_next_s   = 1'b0;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_LOAD: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          wr_en_s     = 1'b1;
          wsum_next_s = csum_add(wsum_r, CSUM_W'(bus.in_data));
          if (cnt_r == LAST_ADDR) begin
            cnt_next_s   = {ADDR_W{1'b0}};
            state_next_s = ST_VERIFY;
          end else begin
            cnt_next_s = cnt_r + ADDR_W'(1);
          end
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      ST_VERIFY: begin
        rd_en_s = 1'b1;
        // Counter holds at the last address instead of wrapping.
        if (cnt_r == LAST_ADDR) begin
          state_next_s = ST_DRAIN;
        end else begin
          cnt_next_s = cnt_r + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (pipe_empty_next_s) begin
          state_next_s = ST_CHECK;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_CHECK: begin
        sum_next_s  = wsum_r;
        busy_next_s = 1'b0;
        if ((rsum_r == wsum_r) && pipe_empty_s) begin
          done_next_s  = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          err_next_s   = 1'b1;
          state_next_s = ST_ERROR;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready = in_ready_s;
  assign bus.wr_en    = wr_en_s;
  assign bus.wr_addr  = wr_en_s ? cnt_r : {ADDR_W{1'b0}};
  assign bus.wr_data  = wr_en_s ? bus.in_data : {DATA_W{1'b0}};
  assign bus.rd_en    = rd_en_s;
  assign bus.rd_addr  = rd_en_s ? cnt_r : {ADDR_W{1'b0}};
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;
  assign sum          = sum_r;
endmodule

// File: tb/tb_sbox_table_loader.sv
// Scoreboard bench for sbox_table_loader: randomized byte streams, a BRAM model
// with optional readback corruption, and a checksum reference model.
module tb_sbox_table_loader;
  import sbox_table_loader_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;
  localparam int RDL   = 2;
  localparam int LAT   = DEPTH + DEPTH + RDL + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, err;
  logic [15:0] sum;

  always #5 clk = ~clk;

  sbox_table_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sbox_table_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(RDL)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .sum   (sum)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int first_acc = 0;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { bit done; bit err; int sum; int lat; } res_t;
  wr_t  wr_q[$];
  res_t res_q[$];
  int   img[DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // BRAM model: registered address, registered data output, optional bit flip.
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] raddr_q = '0;
  bit            corrupt = 1'b0;
  always @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    if (bus.rd_en) raddr_q <= bus.rd_addr;
    bus.rd_data <= mem[raddr_q] ^ ((corrupt && raddr_q == 10'h155) ? 8'h01 : 8'h00);
  end

  // Monitor: write scoreboard, protocol rules, result scoreboard.
  int wcount  = 0;
  bit prev_de = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      wcount  = 0;
      prev_de = 1'b0;
    end else begin
      if (start && !busy) wcount = 0;
      if (bus.wr_en || bus.rd_en) chk("wr_rd_exclusive", bus.wr_en && bus.rd_en, 0);
      if (bus.rd_en) chk("rd_addr_range", bus.rd_addr < DEPTH, 1);
      if (!busy || wcount >= DEPTH) chk("in_ready_outside_load", bus.in_ready, 0);
      if (bus.wr_en) begin
        chk("wr_addr_range", bus.wr_addr < DEPTH, 1);
        chk("wr_expected", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_addr", bus.wr_addr, w.addr);
          chk("wr_data", bus.wr_data, w.data);
        end
        wcount++;
      end
      if ((done || err) && !prev_de) begin
        chk("result_expected", res_q.size() > 0, 1);
        if (res_q.size() > 0) begin
          res_t r;
          r = res_q.pop_front();
          chk("result_done", done, r.done);
          chk("result_err", err, r.err);
          chk("result_sum", sum, r.sum);
          chk("result_busy", busy, 0);
          if (r.lat > 0) chk("done_latency", cyc - first_acc, r.lat);
        end
      end
      prev_de = done || err;
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_wr_en"},    bus.wr_en, 0);
    chk({tag, "_rd_en"},    bus.rd_en, 0);
    chk({tag, "_wr_addr"},  bus.wr_addr, 0);
    chk({tag, "_rd_addr"},  bus.rd_addr, 0);
    chk({tag, "_busy"},     busy, 0);
    chk({tag, "_done"},     done, 0);
    chk({tag, "_err"},      err, 0);
    chk({tag, "_sum"},      sum, 0);
  endtask

  function automatic int byte_of(input int kind, input int i);
    case (kind)
      0:       return i % 256;
      1:       return 32'hEF;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // Offer bytes until n are accepted; expected writes are queued as bytes are offered.
  task automatic send(input int n, input int kind, input bit toggle, input int poke_at, output int got);
    int i = 0;
    int pushed = 0;
    int guard = 0;
    int cur = 0;
    bit ph = 1'b1;
    while (i < n && guard < 4 * DEPTH + 100) begin
      if (pushed == i) begin
        cur = byte_of(kind, i);
        wr_q.push_back('{i, cur});
        pushed++;
      end
      bus.in_data  = 8'(cur);
      bus.in_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      start = (i == poke_at);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        if (i == 0) first_acc = cyc;
        img[i] = cur;
        i++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    got = i;
    if (i < n) chk("send_timeout", i, n);
  endtask

  task automatic run_load(input int kind, input bit toggle, input bit corr, input int poke_load,
                          input bit poke_verify, input bit pulse, input bit lat_chk);
    int got, ws, rs, guard;
    corrupt = corr;
    if (pulse) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
    end
    send(DEPTH, kind, toggle, poke_load, got);
    ws = 0;
    rs = 0;
    for (int a = 0; a < DEPTH; a++) begin
      ws += img[a];
      rs += (corr && a == 'h155) ? (img[a] ^ 1) : img[a];
    end
    ws = ws % 65536;
    rs = rs % 65536;
    res_q.push_back('{(rs == ws), (rs != ws), ws, lat_chk ? LAT : 0});
    if (poke_verify) begin
      repeat (20) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    guard = 0;
    while (res_q.size() > 0 && guard < 3 * DEPTH) begin
      @(posedge clk);
      guard++;
    end
    #1;
    chk("result_wait", res_q.size(), 0);
    chk("writes_drained", wr_q.size(), 0);
    chk("busy_after_check", busy, 0);
  endtask

  initial begin
    int got;
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Counting pattern, in_valid constantly high, latency checked.
    run_load(0, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b1);
    chk("count_sum", sum, 16'hFE00);
    chk("count_done", done, 1);

    // Same pattern with bubbles on every other cycle.
    run_load(0, 1'b1, 1'b0, -1, 1'b0, 1'b1, 1'b0);
    chk("toggle_sum", sum, 16'hFE00);
    chk("toggle_done", done, 1);

    // Readback corruption at 0x155.
    run_load(0, 1'b0, 1'b1, -1, 1'b0, 1'b1, 1'b0);
    chk("corrupt_err", err, 1);
    chk("corrupt_done", done, 0);
    chk("corrupt_sum", sum, 16'hFE00);

    // Reset after 300 accepted bytes.
    corrupt = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    send(300, 2, 1'b0, -1, got);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle("midreset");
    rst = 1'b0;
    wr_q.delete();
    @(posedge clk);
    #1;
    run_load(1, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0);
    chk("ef_sum", sum, 16'hBC00);
    chk("ef_done", done, 1);

    // Random bytes with start pulses during LOAD and VERIFY.
    run_load(2, 1'b0, 1'b0, 500, 1'b1, 1'b1, 1'b0);
    chk("poke_done", done, 1);

    // start in DONE restarts the load.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("restart_done_cleared", done, 0);
    chk("restart_busy", busy, 1);
    run_load(2, ($urandom_range(0, 1) == 1), 1'b0, -1, 1'b0, 1'b0, 1'b0);
    chk("restart_final_done", done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
